// File: rtl/fetch_seq.sv
// Fetch/execute sequencer for the single-cycle RV core: fetches at the current PC over
// a req/rvalid handshake, then pulses exec_en once per instruction. Stops on ebreak or error.
module fetch_seq #(
    parameter int CPU_WIDTH = 32,
    parameter int TIMEOUT   = 255,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run_en,
    input  logic [CPU_WIDTH-1:0] pc,
    output logic                 imem_req,
    output logic [CPU_WIDTH-1:0] imem_addr,
    input  logic                 imem_rvalid,
    input  logic [31:0]          imem_rdata,
    output logic [31:0]          inst,
    output logic                 exec_en,
    output logic                 halted,
    output logic                 err,
    output logic [1:0]           err_code,
    output logic [CNT_WIDTH-1:0] retired
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_EXEC = 3'd2;
    localparam logic [2:0] S_HALT = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    localparam int          WC_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] EBREAK  = 32'h0010_0073;

    logic [2:0]           state_reg, state_next;
    logic [WC_W-1:0]      wait_cnt_reg;
    logic [31:0]          inst_reg;
    logic [1:0]           err_code_reg;
    logic [CNT_WIDTH-1:0] retired_reg;
    logic                 misaligned;
    logic                 timed_out;

    assign misaligned = (pc[1:0] != 2'b00);
    assign timed_out  = (wait_cnt_reg == WC_LAST);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (run_en) state_next = misaligned ? S_ERR : S_REQ;
            end
            S_REQ: begin
                // A response in the last allowed cycle beats the timeout
                if (imem_rvalid)    state_next = S_EXEC;
                else if (timed_out) state_next = S_ERR;
            end
            S_EXEC:  state_next = (inst_reg == EBREAK) ? S_HALT : S_IDLE;
            S_HALT:  state_next = S_HALT;
            S_ERR:   state_next = S_ERR;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            wait_cnt_reg <= '0;
            inst_reg     <= NOP;
            err_code_reg <= 2'b00;
            retired_reg  <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                S_IDLE: begin
                    wait_cnt_reg <= '0;
                    if (run_en && misaligned) err_code_reg <= 2'b01;
                end
                S_REQ: begin
                    if (imem_rvalid) begin
                        inst_reg <= imem_rdata;
                    end else if (timed_out) begin
                        err_code_reg <= 2'b10;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + WC_W'(1);
                    end
                end
                S_EXEC:  retired_reg <= retired_reg + CNT_WIDTH'(1);
                default: ;
            endcase
        end
    end

    // Outputs decode straight from registered state; the address is zeroed outside REQ
    assign imem_req = (state_reg == S_REQ);
    assign exec_en  = (state_reg == S_EXEC);
    assign halted   = (state_reg == S_HALT);
    assign err      = (state_reg == S_ERR);
    assign inst     = inst_reg;
    assign err_code = err_code_reg;
    assign retired  = retired_reg;

    generate
        for (genvar gi = 0; gi < CPU_WIDTH; gi++) begin : g_addr
            assign imem_addr[gi] = pc[gi] & imem_req;
        end
    endgenerate
endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq (TIMEOUT=8): fetch latency, timeout boundary,
// misaligned PC, ebreak halt, mid-REQ reset and run_en gating.
module tb_fetch_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run_en = 1'b0;
    logic [31:0] pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] inst;
    logic        exec_en;
    logic        halted;
    logic        err;
    logic [1:0]  err_code;
    logic [31:0] retired;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_ret = 0;

    fetch_seq #(.CPU_WIDTH(32), .TIMEOUT(8), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .run_en(run_en), .pc(pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst(inst), .exec_en(exec_en), .halted(halted),
        .err(err), .err_code(err_code), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; run_en = 1'b0; imem_rvalid = 1'b0;
        step(); step();
        rst = 1'b0;
        exp_ret = 0;
    endtask

    // Runs one instruction from IDLE; the memory answers 'late' cycles after REQ entry.
    task automatic fetch_one(input logic [31:0] addr, input int late, input logic [31:0] data,
                             input bit keep_run, output int req_cycles, output int exec_cnt,
                             output bit addr_ok, output logic [31:0] exec_inst);
        req_cycles = 0; exec_cnt = 0; addr_ok = 1'b1; exec_inst = 32'hx;
        pc = addr; run_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            imem_rvalid = 1'b0;
            if (imem_req) begin
                req_cycles++;
                if (imem_addr !== addr) addr_ok = 1'b0;
                if (req_cycles == late + 1) begin
                    imem_rvalid = 1'b1; imem_rdata = data;
                end
            end else if (exec_en) begin
                exec_cnt++;
                exec_inst = inst;
                // stray response during EXEC must not touch inst
                imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
                if (!keep_run) run_en = 1'b0;
            end else if (exec_cnt > 0 || err || halted) begin
                break;
            end
        end
        imem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({imem_req, imem_addr, exec_en, inst, halted, err, err_code, retired} !==
            {1'b0, 32'h0, 1'b0, 32'h13, 1'b0, 1'b0, 2'b00, 32'h0}) begin
            fails++;
            $display("FAIL reset: req=%b addr=%h exec=%b inst=%h halt=%b err=%b code=%b ret=%0d",
                     imem_req, imem_addr, exec_en, inst, halted, err, err_code, retired);
        end
        $display("[TB] reset checked");
    endtask

    task automatic test_basic();
        run_en = 1'b1; pc = 32'h8000_0000;
        step();
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h8000_0000) begin
            fails++; $display("FAIL basic_req: req=%b addr=%h want 1/80000000", imem_req, imem_addr);
        end
        imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
        step();
        imem_rvalid = 1'b0; run_en = 1'b0;
        tests++;
        if (exec_en !== 1'b1 || imem_req !== 1'b0 || inst !== 32'h0050_0093 || imem_addr !== 32'h0) begin
            fails++; $display("FAIL basic_exec: exec=%b req=%b inst=%h addr=%h want 1/0/00500093/0",
                              exec_en, imem_req, inst, imem_addr);
        end
        step();
        exp_ret++;
        tests++;
        if (exec_en !== 1'b0 || retired !== exp_ret || inst !== 32'h0050_0093) begin
            fails++; $display("FAIL basic_retire: exec=%b retired=%0d inst=%h want 0/%0d/00500093",
                              exec_en, retired, inst, exp_ret);
        end
        $display("[TB] basic fetch done retired=%0d", retired);
    endtask

    task automatic test_slow();
        int rq, ex; bit aok; logic [31:0] ei;
        fetch_one(32'h8000_0004, 4, 32'h0010_0113, 1'b0, rq, ex, aok, ei);
        exp_ret++;
        tests++;
        if (rq != 5 || ex != 1 || !aok || ei !== 32'h0010_0113) begin
            fails++; $display("FAIL slow: req_cycles=%0d exec=%0d addr_ok=%0d inst=%h want 5/1/1/00100113",
                              rq, ex, aok, ei);
        end
        tests++;
        if (retired !== exp_ret || inst !== 32'h0010_0113) begin
            fails++; $display("FAIL slow_retired: retired=%0d inst=%h want %0d/00100113", retired, inst, exp_ret);
        end
        $display("[TB] slow memory: %0d req cycles", rq);
    endtask

    task automatic test_timeout_edge();
        int rq, ex; bit aok; logic [31:0] ei;
        fetch_one(32'h8000_0008, 7, 32'h0020_0193, 1'b0, rq, ex, aok, ei);
        exp_ret++;
        tests++;
        if (rq != 8 || ex != 1 || err !== 1'b0 || err_code !== 2'b00 || retired !== exp_ret) begin
            fails++; $display("FAIL timeout_edge: req=%0d exec=%0d err=%b code=%b ret=%0d want 8/1/0/00/%0d",
                              rq, ex, err, err_code, retired, exp_ret);
        end
        $display("[TB] response in last REQ cycle accepted");
    endtask

    task automatic test_ebreak();
        int rq, ex, extra; bit aok; logic [31:0] ei;
        fetch_one(32'h8000_000C, 0, 32'h0010_0073, 1'b1, rq, ex, aok, ei);
        exp_ret++;
        tests++;
        if (ex != 1 || halted !== 1'b1 || retired !== exp_ret) begin
            fails++; $display("FAIL ebreak: exec=%0d halted=%b retired=%0d want 1/1/%0d", ex, halted, retired, exp_ret);
        end
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (imem_req || exec_en) extra++;
        end
        tests++;
        if (extra != 0 || halted !== 1'b1 || retired !== exp_ret) begin
            fails++; $display("FAIL ebreak_hold: activity=%0d halted=%b retired=%0d want 0/1/%0d",
                              extra, halted, retired, exp_ret);
        end
        run_en = 1'b0;
        $display("[TB] ebreak halted");
    endtask

    task automatic test_misaligned();
        int reqs;
        do_reset();
        pc = 32'h8000_0002; run_en = 1'b1;
        step();
        tests++;
        if (err !== 1'b1 || err_code !== 2'b01 || imem_req !== 1'b0) begin
            fails++; $display("FAIL misaligned: err=%b code=%b req=%b want 1/01/0", err, err_code, imem_req);
        end
        reqs = 0;
        pc = 32'h8000_0000;
        for (int i = 0; i < 6; i++) begin
            step();
            if (imem_req) reqs++;
        end
        tests++;
        if (reqs != 0 || err !== 1'b1 || err_code !== 2'b01) begin
            fails++; $display("FAIL misaligned_hold: reqs=%0d err=%b code=%b want 0/1/01", reqs, err, err_code);
        end
        $display("[TB] misaligned pc trapped");
    endtask

    task automatic test_timeout();
        int rq, ex; bit aok; logic [31:0] ei;
        do_reset();
        fetch_one(32'h8000_0010, 1000, 32'h0, 1'b1, rq, ex, aok, ei);
        tests++;
        if (rq != 8 || ex != 0 || err !== 1'b1 || err_code !== 2'b10 || imem_req !== 1'b0 || retired !== 32'h0) begin
            fails++; $display("FAIL timeout: req=%0d exec=%0d err=%b code=%b req_now=%b ret=%0d want 8/0/1/10/0/0",
                              rq, ex, err, err_code, imem_req, retired);
        end
        run_en = 1'b0;
        $display("[TB] timeout after %0d req cycles", rq);
    endtask

    task automatic test_reset_mid_req();
        int rq, ex; bit aok; logic [31:0] ei;
        do_reset();
        fetch_one(32'h8000_0000, 0, 32'h0050_0093, 1'b0, rq, ex, aok, ei);
        pc = 32'h8000_0004; run_en = 1'b1;
        step(); step(); step();
        tests++;
        if (imem_req !== 1'b1) begin
            fails++; $display("FAIL midreq_setup: req=%b want 1", imem_req);
        end
        rst = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
        step();
        rst = 1'b0; imem_rvalid = 1'b0; run_en = 1'b0;
        tests++;
        if ({imem_req, imem_addr, exec_en, inst, halted, err, err_code, retired} !==
            {1'b0, 32'h0, 1'b0, 32'h13, 1'b0, 1'b0, 2'b00, 32'h0}) begin
            fails++;
            $display("FAIL midreq_reset: req=%b addr=%h exec=%b inst=%h halt=%b err=%b code=%b ret=%0d",
                     imem_req, imem_addr, exec_en, inst, halted, err, err_code, retired);
        end
        $display("[TB] reset during REQ");
    endtask

    task automatic test_run_gating();
        int act;
        act = 0;
        run_en = 1'b0; pc = 32'h8000_0000;
        for (int i = 0; i < 20; i++) begin
            step();
            if (imem_req || exec_en || err || halted) act++;
        end
        tests++;
        if (act != 0 || retired !== 32'h0) begin
            fails++; $display("FAIL run_gating: activity=%0d retired=%0d want 0/0", act, retired);
        end
        $display("[TB] run_en gating held IDLE");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_slow();
        test_timeout_edge();
        test_ebreak();
        test_misaligned();
        test_timeout();
        test_reset_mid_req();
        test_run_gating();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fetch_seq.md
# fetch_seq

Multi-cycle fetch/execute sequencer for the single-cycle RV core. It fetches each instruction from instruction memory over a request/valid handshake at the core's current PC and holds it stable on `inst`. It then pulses the core's execute enable for exactly one cycle, which advances the PC and commits the register write. It also counts retired instructions and stops on `ebreak`, a misaligned PC or an instruction-memory timeout.

## Interface
- `CPU_WIDTH`, 32, datapath/address width
- `TIMEOUT`, 255, maximum REQ cycles without response before error; must be ≥1
- `CNT_WIDTH`, 32, width of retired-instruction counter
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `run_en`  in  1  permits starting a new fetch from IDLE
- `pc`  in  CPU_WIDTH  current PC from core (`curr_pc`)
- `imem_req`  out  1  fetch request to instruction memory
- `imem_addr`  out  CPU_WIDTH  fetch address
- `imem_rvalid`  in  1  instruction memory response valid
- `imem_rdata`  in  32  instruction memory response data
- `inst`  out  32  latched instruction driven to core
- `exec_en`  out  1  one-cycle commit pulse; drives core PC `ena` and qualifies register write
- `halted`  out  1  sticky; `ebreak` retired
- `err`  out  1  sticky error flag
- `err_code`  out  2  01 = misaligned PC, 10 = fetch timeout, 00 = none
- `retired`  out  CNT_WIDTH  retired-instruction count

## Operation
- FSM states: IDLE, REQ, EXEC, HALT, ERR.
- **IDLE**
  - If `run_en`=0: stay in IDLE.
  - If `run_en`=1 and `pc[1:0]`≠0: go to ERR, set `err_code`=01.
  - If `run_en`=1 and `pc[1:0]`=0: go to REQ, clear `wait_cnt`.
- **REQ**
  - `imem_req`=1, `imem_addr`=`pc`; the address is stable for the whole REQ.
  - If `imem_rvalid`=1: latch `imem_rdata` into `inst`, go to EXEC.
  - Else if `wait_cnt`==TIMEOUT-1: go to ERR, set `err_code`=10.
  - Else: increment `wait_cnt`.
  - A response arriving in the final allowed cycle is accepted; `rvalid` wins over the timeout.
- **EXEC**
  - `exec_en`=1 for this cycle only; `retired`+=1 (wraps modulo 2^CNT_WIDTH).
  - If `inst`==32'h00100073 (`ebreak`): go to HALT. Otherwise go to IDLE.
- **HALT**: `halted`=1. Terminal until `rst`; `run_en` is ignored.
- **ERR**: `err`=1, `err_code` holds its value. Terminal until `rst`.
- `imem_rvalid` outside REQ is ignored; `inst` is never updated outside REQ.
- `run_en` is sampled only in IDLE. Deasserting it during REQ/EXEC finishes the current instruction, then the FSM parks in IDLE.

## Timing
- Reset values:
  - state = IDLE
  - `imem_req`=0, `imem_addr`=0, `exec_en`=0
  - `inst`=32'h00000013 (nop)
  - `halted`=0, `err`=0, `err_code`=00, `retired`=0
- `imem_req` and `exec_en` are decoded from registered state, so they are glitch-free.
- `imem_addr`=0 whenever the FSM is not in REQ.
- Minimum latency per instruction is 3 cycles: IDLE, REQ with `rvalid` in its first cycle, then EXEC.
- General latency is 3+N cycles for a response N cycles late. At most TIMEOUT REQ cycles are allowed.
- `inst` changes on the edge that leaves REQ and is stable throughout EXEC.
- The core PC updates on the edge that ends EXEC, so IDLE always sees the new PC.
- `rst` has priority over every transition. Asserting it in any state (including mid-REQ) returns all outputs to their reset values on the next edge. An in-flight response is dropped.
- `retired` increments exactly once per `exec_en` pulse. `exec_en` never asserts in consecutive cycles.

## Test plan
- **Basic fetch**
  - Stimulus: `rst` for 2 cycles; then `run_en`=1, `pc`=0x80000000, memory returns `rvalid`+0x00500093 in the first REQ cycle.
  - Required: `imem_req` high 1 cycle with addr 0x80000000; `exec_en` pulse the next cycle; `inst`=0x00500093; `retired`=1.
- **Slow memory**
  - Stimulus: `rvalid` arrives 4 cycles after REQ entry.
  - Required: `imem_req` high 5 cycles with constant `imem_addr`; one `exec_en`; `retired` increments by 1.
- **Timeout** (TIMEOUT=8)
  - Stimulus: no response.
  - Required: `imem_req` high exactly 8 cycles; then `err`=1, `err_code`=10; `imem_req`=0; no `exec_en`.
  - Repeat with `rvalid` in the 8th REQ cycle: the instruction is accepted and no error is raised.
- **Misaligned PC**
  - Stimulus: `pc`=0x80000002, `run_en`=1.
  - Required: ERR after 1 IDLE cycle; `err_code`=01; `imem_req` never asserted.
- **ebreak**
  - Stimulus: fetch returns 0x00100073.
  - Required: `exec_en` pulse; `retired`+1; `halted`=1 next cycle; no further `imem_req` while `run_en`=1.
- **Reset and run_en gating**
  - Stimulus: `rst` during the 3rd cycle of REQ.
  - Required: next cycle all outputs at reset values, `inst`=0x00000013.
  - Stimulus: `run_en`=0 in IDLE.
  - Required: FSM stays in IDLE indefinitely.
